// File: rtl/pcm_frame_packer_if.sv
// rtl/pcm_frame_packer_if.sv - sample input and frame word stream bundle for pcm_frame_packer
//
// Purpose: groups the sample strobe/data, the outgoing valid/ready word stream and
//          the dropped-frame counter into one bundle.
// Signals:
//   in_valid   sample-set strobe            (master -> slave)
//   in_data    CH*DW packed samples          (master -> slave)
//   out_ready  downstream accepts word       (master -> slave)
//   out_valid  stream word valid             (slave -> master)
//   out_data   DW-bit stream word            (slave -> master)
//   out_last   final (checksum) word flag    (slave -> master)
//   ovf_cnt    saturating dropped-frame count (slave -> master)
interface pcm_frame_packer_if #(
    parameter int CH = 4,
    parameter int DW = 16
);
    logic               in_valid;
    logic [CH*DW-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic               out_last;
    logic [15:0]        ovf_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last, ovf_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last, ovf_cnt
    );
endinterface

// File: rtl/pcm_frame_packer.sv
// rtl/pcm_frame_packer.sv - buffers PCM sample sets in a frame FIFO and streams them as header/samples/checksum
//
// Purpose: snapshots CH parallel DW-bit samples on each in_valid strobe into a
//          DEPTH-frame FIFO tagged with an 8-bit sequence number, then emits each
//          frame as CH+2 stream words: {SYNC, seq}, ch0..chCH-1, XOR checksum.
//          Frames arriving while the FIFO is full are dropped and counted.
// Ports:
//   CLKDIVH2   decimated sample clock, posedge
//   RST        asynchronous active-high reset
//   bus        pcm_frame_packer_if slave modport (in_valid/in_data, out_* stream, ovf_cnt)
module pcm_frame_packer #(
    parameter int         CH    = 4,
    parameter int         DW    = 16,
    parameter int         DEPTH = 4,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input  logic                 CLKDIVH2,
    input  logic                 RST,
    pcm_frame_packer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(CH + 2);

    typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;

    state_t             state, state_n;
    logic [IW-1:0]      idx, idx_n;
    logic [DW-1:0]      csum, csum_n;
    logic [DW-1:0]      sample;

    logic [CH*DW-1:0]   mem_data [DEPTH];
    logic [7:0]         mem_seq  [DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic [7:0]         seq;
    logic [CH*DW-1:0]   head_data;
    logic [7:0]         head_seq;

    logic full, empty, hs, pop, push, drop;

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (wr_ptr == rd_ptr);
    assign head_data = mem_data[rd_ptr[AW-1:0]];
    assign head_seq  = mem_seq[rd_ptr[AW-1:0]];

    assign hs   = bus.out_valid && bus.out_ready;
    assign pop  = hs && (state == CSUM);
    // A checksum handshake frees the head slot on the same edge, so a full FIFO
    // can still take the incoming frame into that slot.
    assign push = bus.in_valid && (!full || pop);
    assign drop = bus.in_valid && full && !pop;

    // Frame storage carries no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge CLKDIVH2) begin
        if (push) begin
            mem_data[wr_ptr[AW-1:0]] <= bus.in_data;
            mem_seq[wr_ptr[AW-1:0]]  <= seq;
        end
    end

    always_ff @(posedge CLKDIVH2 or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            idx         <= '0;
            csum        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            seq         <= '0;
            bus.ovf_cnt <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            csum  <= csum_n;
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            // seq advances on dropped frames too so receivers can see the gap.
            if (bus.in_valid) seq <= seq + 8'd1;
            if (drop && (bus.ovf_cnt != 16'hFFFF)) bus.ovf_cnt <= bus.ovf_cnt + 16'd1;
        end
    end

    always_comb begin
        sample = '0;
        for (int i = 0; i < CH; i++) begin
            if (idx == IW'(i + 1)) sample = head_data[i*DW +: DW];
        end
    end

    // Outputs are decoded from registered state and FIFO head only, so they hold
    // steady under backpressure and never depend on out_ready.
    always_comb begin
        state_n       = state;
        idx_n         = idx;
        csum_n        = csum;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) state_n = HDR;
            end
            HDR: begin
                bus.out_valid = 1'b1;
                bus.out_data  = DW'({SYNC, head_seq});
                if (hs) begin
                    state_n = DATA;
                    idx_n   = IW'(1);
                    csum_n  = '0;
                end
            end
            DATA: begin
                bus.out_valid = 1'b1;
                bus.out_data  = sample;
                if (hs) begin
                    csum_n = csum ^ sample;
                    if (idx == IW'(CH)) state_n = CSUM;
                    else                idx_n   = idx + IW'(1);
                end
            end
            CSUM: begin
                bus.out_valid = 1'b1;
                bus.out_last  = 1'b1;
                bus.out_data  = csum;
                if (hs) begin
                    // Non-empty after this pop: another frame was queued, or one lands now.
                    state_n = ((count > (AW+1)'(1)) || push) ? HDR : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pcm_frame_packer.sv
// tb/tb_pcm_frame_packer.sv - scoreboard bench for pcm_frame_packer
module tb_pcm_frame_packer;
    localparam int CH    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic CLKDIVH2 = 1'b0;
    logic RST      = 1'b1;

    pcm_frame_packer_if #(.CH(CH), .DW(DW)) bus ();

    pcm_frame_packer #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .SYNC(8'hA5)) dut (
        .CLKDIVH2 (CLKDIVH2),
        .RST      (RST),
        .bus      (bus)
    );

    always #5 CLKDIVH2 = ~CLKDIVH2;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [16:0] exp_q [$];
    int          occ;
    logic [7:0]  mseq;
    logic [15:0] exp_ovf;
    int          frames_done = 0;
    bit          prev_hold;
    logic [16:0] prev_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference frame: header {A5,seq}, samples in channel order, XOR of samples flagged last.
    task automatic model_frame(input logic [7:0] s, input logic [CH*DW-1:0] d);
        logic [15:0] x;
        x = 16'h0000;
        exp_q.push_back({1'b0, 8'hA5, s});
        for (int i = 0; i < CH; i++) begin
            exp_q.push_back({1'b0, d[i*DW +: DW]});
            x = x ^ d[i*DW +: DW];
        end
        exp_q.push_back({1'b1, x});
    endtask

    // Monitor + reference model: everything observed here happens at the next posedge.
    always @(negedge CLKDIVH2) begin
        logic        hs, pop_now;
        logic [16:0] w;
        if (RST) begin
            exp_q.delete();
            occ       = 0;
            mseq      = 8'd0;
            exp_ovf   = 16'd0;
            prev_hold = 1'b0;
        end else begin
            check("ovf_cnt", {16'd0, bus.ovf_cnt}, {16'd0, exp_ovf});
            if (prev_hold) begin
                check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                check("hold_word", {15'd0, bus.out_last, bus.out_data}, {15'd0, prev_word});
            end
            hs      = bus.out_valid && bus.out_ready;
            pop_now = hs && bus.out_last;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h, required no word at %0t",
                             {bus.out_last, bus.out_data}, $time);
                end else begin
                    w = exp_q.pop_front();
                    check("stream_word", {15'd0, bus.out_last, bus.out_data}, {15'd0, w});
                end
                if (bus.out_last) frames_done++;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_word = {bus.out_last, bus.out_data};
            if (bus.in_valid) begin
                if (occ < DEPTH || pop_now) begin
                    model_frame(mseq, bus.in_data);
                    occ++;
                end else if (exp_ovf != 16'hFFFF) begin
                    exp_ovf = exp_ovf + 16'd1;
                end
                mseq = mseq + 8'd1;
            end
            if (pop_now) occ--;
        end
    end

    task automatic tick();
        @(posedge CLKDIVH2);
        #1;
    endtask

    task automatic send(input logic [CH*DW-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLKDIVH2);
        #2 RST = 1'b1;
        @(negedge CLKDIVH2);
        @(posedge CLKDIVH2);
        #2 RST = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && !bus.out_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        check("drain_done", {31'd0, done}, 32'd1);
    endtask

    // in_valid into an empty FIFO: nothing the cycle after the edge, header one edge later.
    task automatic send_check_header(input logic [CH*DW-1:0] d, input logic [15:0] hdr);
        send(d);
        check("latency_idle", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("latency_hdr", {15'd0, bus.out_valid, bus.out_data}, {15'd0, 1'b1, hdr});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t1_words [6];
        int          base;
        bit          seen;
        t1_words = '{16'hA500, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        RST           = 1'b1;
        #3;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_last",  {31'd0, bus.out_last},  32'd0);
        check("rst_data",  {16'd0, bus.out_data},  32'd0);
        check("rst_ovf",   {16'd0, bus.ovf_cnt},   32'd0);
        repeat (2) @(posedge CLKDIVH2);
        #2 RST = 1'b0;
        tick();

        // 1: single frame, ready high, six consecutive words
        bus.out_ready = 1'b1;
        send({16'h0004, 16'h0003, 16'h0002, 16'h0001});
        check("t1_latency", {31'd0, bus.out_valid}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t1_word", {15'd0, bus.out_last, bus.out_data},
                  {15'd0, (k == 5), t1_words[k]});
        end
        wait_idle(20);

        // 2: backpressure while sample word 0002 is presented
        send({16'h4444, 16'h3333, 16'h0002, 16'h1111});
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid && bus.out_data == 16'h0002) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("t2_found", {31'd0, seen}, 32'd1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t2_stall", {15'd0, bus.out_valid, bus.out_data}, {15'd0, 1'b1, 16'h0002});
        end
        bus.out_ready = 1'b1;
        wait_idle(20);

        // 3: overflow with ready low, then back-to-back drain
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom, $urandom};
            tick();
        end
        bus.in_valid = 1'b0;
        check("t3_ovf", {16'd0, bus.ovf_cnt}, 32'd2);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4 * (CH + 2); k++) begin
            check("t3_b2b", {31'd0, bus.out_valid}, 32'd1);
            tick();
        end
        check("t3_empty", {31'd0, bus.out_valid}, 32'd0);
        send_check_header({$urandom, $urandom}, 16'hA506);
        wait_idle(20);

        // 4: full FIFO, new frame on the same edge as the checksum handshake
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom, $urandom};
            tick();
        end
        bus.in_valid = 1'b0;
        base = frames_done;
        bus.out_ready = 1'b1;
        repeat (CH + 1) tick();
        check("t4_at_csum", {15'd0, bus.out_last, bus.out_valid}, 32'd3);
        send({$urandom, $urandom});
        check("t4_ovf", {16'd0, bus.ovf_cnt}, 32'd0);
        wait_idle(60);
        check("t4_frames", frames_done - base, DEPTH + 1);

        // 5: asynchronous reset in the middle of the sample words
        bus.out_ready = 1'b1;
        send({16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0001});
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid && bus.out_data == 16'h0001) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("t5_found", {31'd0, seen}, 32'd1);
        #1 RST = 1'b1;
        #1;
        check("t5_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t5_last",  {31'd0, bus.out_last},  32'd0);
        @(negedge CLKDIVH2);
        @(posedge CLKDIVH2);
        #2 RST = 1'b0;
        tick();
        send_check_header({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 16'hA500);
        wait_idle(20);

        // 6: random samples, random ready, one frame every 8 cycles
        for (int f = 0; f < 1000; f++) begin
            for (int c = 0; c < 8; c++) begin
                bus.out_ready = 1'($urandom);
                bus.in_valid  = (c == 0);
                if (c == 0) bus.in_data = {$urandom, $urandom};
                tick();
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle(200);
        check("t6_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
